rf_multiport: RTL and testbench



---
 rtl/core.sv | 53 +++++
 rtl/rf_scoreboard.sv | 28 ++
 rtl/rf_multiport.sv | 63 ++++++
 tb/tb_rf_multiport.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/core.sv
// core: shared RV32I pipeline types, register-file port structs and reset constants
package core;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW = 5;
  typedef struct packed {
    logic [AW-1:0] reg_addr;
    logic en;
  } rf_read_req_t;
  typedef struct packed {
    logic [XLEN-1:0] value;
    logic valid;
  } rf_read_rsp_t;
  typedef struct packed {
    logic [AW-1:0] reg_addr;
    logic [XLEN-1:0] value;
    logic en;
  } rf_write_req_t;
  typedef struct packed {
    logic valid;
    logic done;
  } rf_write_rsp_t;
  typedef struct packed {
    logic [AW-1:0] reg_addr;
    logic en;
  } rf_rsv_req_t;
  typedef struct packed {
    logic [AW-1:0] reg_addr;
    logic [XLEN-1:0] value;
    logic en;
  } reg_byp_t;
  typedef struct packed {
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] store_data;
    logic [AW-1:0] rd_addr;
    logic mem_rd;
    logic mem_wr;
    logic reg_wr;
  } ex_mem_t;
  localparam rf_read_req_t rf_read_req_rst = '0;
  localparam rf_read_rsp_t rf_read_rsp_rst = '0;
  localparam rf_write_req_t rf_write_req_rst = '0;
  localparam rf_write_rsp_t rf_write_rsp_rst = '0;
  localparam rf_rsv_req_t rf_rsv_req_rst = '0;
  localparam reg_byp_t reg_byp_rst = '0;
  localparam ex_mem_t ex_mem_rst = '0;
  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + 6'(v[i]);
    return c;
  endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: pending-write bits (clk/rst; wr_clr/rsv_req set-clear sources; flush) -> pend_mask, pend_cnt, clr_mask
module rf_scoreboard
  import core::*;
#(
  parameter int NUM_WR = 1,
  parameter int NUM_RSV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  rf_rsv_req_t wr_clr  [NUM_WR],
  input  rf_rsv_req_t rsv_req [NUM_RSV],
  input  logic        flush,
  output logic [31:0] clr_mask,
  output logic [31:0] pend_mask,
  output logic [5:0]  pend_cnt
);
  logic [31:0] pend_d, pend_q, set_mask;
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    for (int i = 0; i < NUM_WR; i++) if (wr_clr[i].en) clr_mask[wr_clr[i].reg_addr] = 1'b1;
    for (int i = 0; i < NUM_RSV; i++) if (rsv_req[i].en) set_mask[rsv_req[i].reg_addr] = 1'b1;
    pend_d = flush ? '0 : ((pend_q & ~clr_mask) | set_mask) & ~32'd1;
  end
  always_ff @(posedge clk) pend_q <= rst ? '0 : pend_d;
  assign pend_mask = pend_q;
  assign pend_cnt = popcount32(pend_q);
endmodule

// File: rtl/rf_multiport.sv
// rf_multiport: 32x32 register file (clk/rst; rd_req->rd_rsp, wr_req->wr_rsp, rsv_req, flush) with pending scoreboard, pend_mask, pend_cnt
module rf_multiport
  import core::*;
#(
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1,
  parameter int NUM_RSV = 1,
  parameter int BYPASS = 1,
  parameter int RST_CLEAR = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  rf_read_req_t  rd_req  [NUM_RD],
  output rf_read_rsp_t  rd_rsp  [NUM_RD],
  input  rf_write_req_t wr_req  [NUM_WR],
  output rf_write_rsp_t wr_rsp  [NUM_WR],
  input  rf_rsv_req_t   rsv_req [NUM_RSV],
  input  logic          flush,
  output logic [31:0]   pend_mask,
  output logic [5:0]    pend_cnt
);
  logic [31:0] regs_d [NREG];
  logic [31:0] regs_q [NREG];
  rf_read_rsp_t rd_rsp_d [NUM_RD];
  rf_read_rsp_t rd_rsp_q [NUM_RD];
  rf_write_rsp_t wr_rsp_d [NUM_WR];
  rf_write_rsp_t wr_rsp_q [NUM_WR];
  rf_rsv_req_t wr_clr [NUM_WR];
  logic [31:0] clr_mask;
  rf_scoreboard #(.NUM_WR(NUM_WR), .NUM_RSV(NUM_RSV)) u_sb (
    .clk(clk),
    .rst(rst),
    .wr_clr(wr_clr),
    .rsv_req(rsv_req),
    .flush(flush),
    .clr_mask(clr_mask),
    .pend_mask(pend_mask),
    .pend_cnt(pend_cnt)
  );
  always_comb begin
    regs_d = regs_q;
    for (int i = 0; i < NUM_WR; i++) begin
      wr_clr[i] = '{reg_addr: wr_req[i].reg_addr, en: wr_req[i].en};
      wr_rsp_d[i] = '{valid: wr_req[i].en, done: wr_req[i].en};
      if (wr_req[i].en) regs_d[wr_req[i].reg_addr] = wr_req[i].value;
    end
    regs_d[0] = '0;
  end
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_rsp_d[p].value = !rd_req[p].en ? '0 : BYPASS != 0 ? regs_d[rd_req[p].reg_addr] : regs_q[rd_req[p].reg_addr];
      rd_rsp_d[p].valid = rd_req[p].en && (!pend_mask[rd_req[p].reg_addr] || (BYPASS != 0 && clr_mask[rd_req[p].reg_addr]));
    end
  end
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_RD; p++) rd_rsp_q[p] <= rst ? rf_read_rsp_rst : rd_rsp_d[p];
    for (int i = 0; i < NUM_WR; i++) wr_rsp_q[i] <= rst ? rf_write_rsp_rst : wr_rsp_d[i];
    if (!rst) regs_q <= regs_d;
    else if (RST_CLEAR != 0) regs_q <= '{default: '0};
  end
  assign rd_rsp = rd_rsp_q;
  assign wr_rsp = wr_rsp_q;
endmodule

// File: tb/tb_rf_multiport.sv
// tb_rf_multiport: scoreboard bench driving a bypassing and a non-bypassing register file in lockstep
module tb_rf_multiport;
  import core::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  always #5 clk = ~clk;
  rf_read_req_t rd_req [2];
  rf_read_rsp_t rsp_a [2];
  rf_read_rsp_t rsp_b [2];
  rf_write_req_t wr_req [2];
  rf_write_rsp_t wrs_a [2];
  rf_write_rsp_t wrs_b [2];
  rf_rsv_req_t rsv_req [2];
  logic [31:0] pm_a, pm_b;
  logic [5:0] pc_a, pc_b;
  logic [31:0] m_regs [32];
  logic [31:0] m_pend;
  typedef struct {
    int kind;
    int port;
    logic [32:0] exp;
  } exp_t;
  exp_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;
  rf_multiport #(.NUM_RD(2), .NUM_WR(2), .NUM_RSV(2), .BYPASS(1), .RST_CLEAR(1)) u_byp (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_rsp(rsp_a), .wr_req(wr_req), .wr_rsp(wrs_a),
    .rsv_req(rsv_req), .flush(flush), .pend_mask(pm_a), .pend_cnt(pc_a)
  );
  rf_multiport #(.NUM_RD(2), .NUM_WR(2), .NUM_RSV(2), .BYPASS(0), .RST_CLEAR(1)) u_nobyp (
    .clk(clk), .rst(rst), .rd_req(rd_req), .rd_rsp(rsp_b), .wr_req(wr_req), .wr_rsp(wrs_b),
    .rsv_req(rsv_req), .flush(flush), .pend_mask(pm_b), .pend_cnt(pc_b)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      rd_req[i] = '0;
      wr_req[i] = '0;
      rsv_req[i] = '0;
    end
    flush = 1'b0;
  endtask
  task automatic rd(input int p, input int a);
    rd_req[p] = '{reg_addr: 5'(a), en: 1'b1};
  endtask
  task automatic wr(input int p, input int a, input logic [31:0] v);
    wr_req[p] = '{reg_addr: 5'(a), value: v, en: 1'b1};
  endtask
  task automatic rsv(input int p, input int a);
    rsv_req[p] = '{reg_addr: 5'(a), en: 1'b1};
  endtask
  task automatic predict();
    logic [4:0] a;
    logic [31:0] vb, vn;
    logic hit;
    for (int p = 0; p < 2; p++) begin
      a = rd_req[p].reg_addr;
      vn = m_regs[a];
      vb = vn;
      hit = 1'b0;
      for (int w = 0; w < 2; w++)
        if (wr_req[w].en && wr_req[w].reg_addr == a && a != 0) begin
          vb = wr_req[w].value;
          hit = 1'b1;
        end
      if (rst || !rd_req[p].en) begin
        exp_q.push_back('{0, p, 33'd0});
        exp_q.push_back('{1, p, 33'd0});
      end else begin
        exp_q.push_back('{0, p, {!m_pend[a] || hit, vb}});
        exp_q.push_back('{1, p, {!m_pend[a], vn}});
      end
    end
    for (int w = 0; w < 2; w++)
      exp_q.push_back('{2, w, (rst || !wr_req[w].en) ? 33'd0 : 33'd3});
  endtask
  task automatic update();
    if (rst) begin
      m_pend = '0;
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
    end else begin
      for (int w = 0; w < 2; w++)
        if (wr_req[w].en && wr_req[w].reg_addr != 0) begin
          m_regs[wr_req[w].reg_addr] = wr_req[w].value;
          m_pend[wr_req[w].reg_addr] = 1'b0;
        end
      for (int r = 0; r < 2; r++)
        if (rsv_req[r].en && rsv_req[r].reg_addr != 0) m_pend[rsv_req[r].reg_addr] = 1'b1;
      if (flush) m_pend = '0;
    end
  endtask
  task automatic step();
    exp_t e;
    predict();
    @(posedge clk);
    update();
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.kind == 0) check($sformatf("rd_byp%0d", e.port), {31'd0, rsp_a[e.port].valid, rsp_a[e.port].value}, 64'(e.exp));
      else if (e.kind == 1) check($sformatf("rd_nobyp%0d", e.port), {31'd0, rsp_b[e.port].valid, rsp_b[e.port].value}, 64'(e.exp));
      else begin
        check($sformatf("wr_rsp_byp%0d", e.port), 64'({wrs_a[e.port].valid, wrs_a[e.port].done}), 64'(e.exp));
        check($sformatf("wr_rsp_nobyp%0d", e.port), 64'({wrs_b[e.port].valid, wrs_b[e.port].done}), 64'(e.exp));
      end
    end
    check("pend_mask_byp", 64'(pm_a), 64'(m_pend));
    check("pend_mask_nobyp", 64'(pm_b), 64'(m_pend));
    check("pend_cnt_byp", 64'(pc_a), 64'($countones(m_pend)));
    check("pend_cnt_nobyp", 64'(pc_b), 64'($countones(m_pend)));
  endtask
  initial begin
    m_pend = '0;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      idle(); rd(0, 2 * i); rd(1, 2 * i + 1); step();
    end
    idle(); wr(0, 5, 32'hDEADBEEF); step();
    idle(); rd(0, 5); step();
    check("x5_value", 64'(rsp_a[0].value), 64'h00000000DEADBEEF);
    check("x5_valid", 64'(rsp_a[0].valid), 64'd1);
    idle(); wr(0, 0, 32'h1234); step();
    check("x0_wr_done", 64'(wrs_a[0].done), 64'd1);
    idle(); rd(0, 0); step();
    check("x0_value", 64'(rsp_a[0].value), 64'd0);
    idle(); wr(1, 7, 32'h11); step();
    idle(); wr(0, 7, 32'h55); rd(0, 7); step();
    check("x7_bypass", 64'(rsp_a[0].value), 64'h55);
    check("x7_nobypass", 64'(rsp_b[0].value), 64'h11);
    idle(); rd(1, 7); step();
    idle(); rsv(0, 3); step();
    idle(); rd(0, 3); step();
    check("x3_pending_valid", 64'(rsp_a[0].valid), 64'd0);
    check("x3_pend_cnt", 64'(pc_a), 64'd1);
    idle(); wr(0, 3, 32'd9); step();
    idle(); rd(0, 3); step();
    check("x3_cleared_value", 64'({rsp_a[0].valid, rsp_a[0].value}), 64'h1_0000_0009);
    check("x3_cleared_cnt", 64'(pc_a), 64'd0);
    idle(); rsv(1, 3); step();
    idle(); wr(1, 3, 32'd10); rd(0, 3); rd(1, 3); step();
    idle(); rsv(0, 4); wr(0, 4, 32'd2); step();
    check("x4_pend", 64'(pm_a[4]), 64'd1);
    idle(); rd(0, 4); step();
    check("x4_value", 64'(rsp_a[0].value), 64'd2);
    idle(); wr(1, 4, 32'd2); step();
    idle(); rsv(0, 1); rsv(1, 2); step();
    idle(); rsv(0, 3); step();
    idle(); flush = 1'b1; rsv(1, 6); wr(0, 9, 32'hCAFE); step();
    check("flush_mask", 64'(pm_a), 64'd0);
    idle(); rd(0, 9); rd(1, 6); step();
    idle(); wr(0, 8, 32'd1); wr(1, 8, 32'd2); step();
    idle(); rd(0, 8); step();
    check("x8_conflict", 64'(rsp_a[0].value), 64'd2);
    idle(); rsv(0, 0); step();
    for (int c = 0; c < 400; c++) begin
      idle();
      rst = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 19) == 0);
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 3) != 0) rd(p, $urandom_range(0, 31));
        if ($urandom_range(0, 1) != 0) wr(p, $urandom_range(0, 31), $urandom);
        if ($urandom_range(0, 2) == 0) rsv(p, $urandom_range(0, 31));
      end
      step();
    end
    idle();
    rst = 1'b0;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
